// File: rtl/mem_bank_fu_if.sv
// mem_bank_fu_if: transfer-control, write-source, SRAM and read-return signals of the banked memory unit
interface mem_bank_fu_if #(
   parameter int AW = 22,
   parameter int DW = 64,
   parameter int CW = 7
);
   logic          i_start;
   logic          i_rd;
   logic [AW-1:0] i_addr;
   logic [AW-1:0] i_stride;
   logic [CW-1:0] i_count;
   logic [DW-1:0] i_wr_data;
   logic          i_wr_vld;
   logic          o_wr_rdy;
   logic [AW-1:0] o_mem_addr;
   logic          o_mem_en;
   logic          o_mem_wr_en;
   logic [DW-1:0] o_mem_wr_data;
   logic [DW-1:0] i_mem_rd_data;
   logic [DW-1:0] o_rd_data;
   logic          o_rd_vld;
   logic [CW-1:0] o_rd_idx;
   logic          o_busy;
   logic          o_done;
   logic          o_conflict_stall;
   modport slave (
      input  i_start, i_rd, i_addr, i_stride, i_count, i_wr_data, i_wr_vld, i_mem_rd_data,
      output o_wr_rdy, o_mem_addr, o_mem_en, o_mem_wr_en, o_mem_wr_data,
             o_rd_data, o_rd_vld, o_rd_idx, o_busy, o_done, o_conflict_stall
   );
   modport master (
      output i_start, i_rd, i_addr, i_stride, i_count, i_wr_data, i_wr_vld, i_mem_rd_data,
      input  o_wr_rdy, o_mem_addr, o_mem_en, o_mem_wr_en, o_mem_wr_data,
             o_rd_data, o_rd_vld, o_rd_idx, o_busy, o_done, o_conflict_stall
   );
endinterface

// File: rtl/mem_bank_fu.sv
// mem_bank_fu: strided block-transfer memory unit over interleaved busy-timed banks, with fixed-latency read return
module mem_bank_fu #(
   parameter int AW        = 22,
   parameter int DW        = 64,
   parameter int CW        = 7,
   parameter int NUM_BANKS = 16,
   parameter int BANK_BUSY = 4,
   parameter int READ_LAT  = 11
) (
   input logic         clk,
   input logic         rst,
   mem_bank_fu_if.slave bus
);
   localparam int BB = $clog2(NUM_BANKS);
   localparam int KW = $clog2(BANK_BUSY + 1);
   localparam int DL = READ_LAT > 1 ? READ_LAT - 1 : 1;
   localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2;
   logic [1:0]                   state;
   logic [AW-1:0]                addr, stride;
   logic [CW-1:0]                count, idx, last_idx;
   logic                         rd, done;
   logic [KW-1:0]                bank_cnt [NUM_BANKS];
   logic [BB-1:0]                bank;
   logic                         run, free, issue, last, last_ret, take;
   logic [READ_LAT-1:0]          vpipe;
   logic [READ_LAT:0]            vsh;
   logic [READ_LAT-1:0][CW-1:0]  ipipe;
   logic [READ_LAT:0][CW-1:0]    ish;
   logic [DL-1:0][DW-1:0]        dpipe;
   logic [DL:0][DW-1:0]          dsh;
   always_comb begin
      run      = state == RUN;
      bank     = addr[BB-1:0];
      free     = bank_cnt[bank] == '0;
      issue    = run && free && (rd || bus.i_wr_vld);
      last_idx = count - CW'(1);
      last     = idx == last_idx;
      take     = state == IDLE && bus.i_start;
      vsh      = {vpipe, issue && rd};
      ish      = {ipipe, idx};
      dsh      = {dpipe, bus.i_mem_rd_data};
      last_ret = state == DRAIN && vsh[READ_LAT] && ish[READ_LAT] == last_idx;
   end
   assign bus.o_mem_en         = issue;
   assign bus.o_mem_addr       = issue ? addr : '0;
   assign bus.o_mem_wr_en      = issue && !rd;
   assign bus.o_wr_rdy         = issue && !rd;
   assign bus.o_mem_wr_data    = issue && !rd ? bus.i_wr_data : '0;
   assign bus.o_rd_vld         = vsh[READ_LAT];
   assign bus.o_rd_idx         = vsh[READ_LAT] ? ish[READ_LAT] : '0;
   assign bus.o_rd_data        = vsh[READ_LAT] ? dsh[READ_LAT-1] : '0;
   assign bus.o_busy           = state != IDLE;
   assign bus.o_done           = done;
   assign bus.o_conflict_stall = run && !free;
   // Counters run in every state so bank occupancy carries into the next transfer.
   always_ff @(posedge clk or negedge rst)
      if (!rst)
         for (int b = 0; b < NUM_BANKS; b++) bank_cnt[b] <= '0;
      else
         for (int b = 0; b < NUM_BANKS; b++)
            bank_cnt[b] <= issue && bank == BB'(b) ? KW'(BANK_BUSY - 1) :
                           bank_cnt[b] != '0 ? bank_cnt[b] - KW'(1) : '0;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state  <= IDLE;
         addr   <= '0;
         stride <= '0;
         count  <= '0;
         idx    <= '0;
         rd     <= 1'b0;
         done   <= 1'b0;
      end else begin
         done <= (take && bus.i_count == '0) || (issue && last && !rd) || last_ret;
         if (take && bus.i_count != '0) begin
            state  <= RUN;
            addr   <= bus.i_addr;
            stride <= bus.i_stride;
            count  <= bus.i_count;
            rd     <= bus.i_rd;
            idx    <= '0;
         end else if (issue) begin
            addr <= addr + stride;
            idx  <= idx + CW'(1);
            if (last) state <= rd ? DRAIN : IDLE;
         end else if (last_ret) begin
            state <= IDLE;
         end
      end
   // SRAM data lands one cycle after issue, so its delay line is one stage shorter.
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         vpipe <= '0;
         ipipe <= '0;
         dpipe <= '0;
      end else begin
         vpipe <= vsh[READ_LAT-1:0];
         ipipe <= ish[READ_LAT-1:0];
         dpipe <= dsh[DL-1:0];
      end
endmodule

// File: doc/mem_bank_fu.md
Name: mem_bank_fu

Overview:
Parametrised memory functional unit for the Cray-1A model. It is the banked successor of the single-bank memory controller. It runs one strided block transfer at a time, either a read stream (memory to registers) or a write stream (registers to memory). It models an interleaved memory of NUM_BANKS banks, each with a bank busy time, and stalls issue on bank conflicts. A return pipeline delivers read data with a fixed latency and an element index, so that V/B/T/A/S register write-back is decoupled from the controller.

Parameters:
AW, 22, memory word-address width
DW, 64, data width
CW, 7, element-count width (max transfer length 2^CW-1)
NUM_BANKS, 16, number of interleaved banks; power of 2, >=2
BANK_BUSY, 4, cycles a bank is unavailable after an access, counting the access cycle; >=1
READ_LAT, 11, cycles from read issue to o_rd_vld; >=1

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
i_start  in  1  start transfer; sampled only in IDLE
i_rd  in  1  1=read stream, 0=write stream
i_addr  in  AW  start address
i_stride  in  AW  address increment, two's complement modulo 2^AW
i_count  in  CW  number of elements
i_wr_data  in  DW  write element from source register
i_wr_vld  in  1  i_wr_data valid
o_wr_rdy  out  1  write element consumed this cycle
o_mem_addr  out  AW  SRAM address
o_mem_en  out  1  SRAM access this cycle
o_mem_wr_en  out  1  SRAM write this cycle
o_mem_wr_data  out  DW  SRAM write data
i_mem_rd_data  in  DW  SRAM read data, valid the cycle after a read o_mem_en
o_rd_data  out  DW  returned read element
o_rd_vld  out  1  o_rd_data valid
o_rd_idx  out  CW  element index of o_rd_data, 0-based
o_busy  out  1  transfer in progress
o_done  out  1  one-cycle pulse at transfer completion
o_conflict_stall  out  1  issue blocked by a busy bank this cycle

Behaviour:
- Reset (rst low, async): state IDLE; all bank counters 0; return pipeline valids cleared. All outputs read 0; o_mem_addr is 0.
- Bank of an address: addr[log2(NUM_BANKS)-1:0].
- Each bank has a counter. On access it loads BANK_BUSY-1. It decrements toward 0 every cycle, in any state. A bank is free when its counter is 0, so consecutive accesses to one bank are spaced BANK_BUSY cycles apart.
- State IDLE:
  - i_start with i_count!=0: latch addr, stride, count, rd; element index=0; go to RUN next cycle.
  - i_start with i_count==0: no access; o_done pulses the next cycle; stay IDLE.
- State RUN (per cycle):
  - Target = current address. Issue occurs when the target bank is free and, for writes, i_wr_vld=1.
  - On issue: o_mem_en=1, o_mem_addr=current address. Write streams also assert o_mem_wr_en=1, o_wr_rdy=1, and o_mem_wr_data=i_wr_data, all combinational in that cycle.
  - After issue: address += stride (wraps mod 2^AW); index += 1; the bank counter loads.
  - o_conflict_stall=1 when the bank is busy, regardless of i_wr_vld.
  - A write with the bank free but i_wr_vld=0 is a plain wait: no stall flag, no access.
  - Issue of the last element:
    - write: go to IDLE, o_done pulses next cycle.
    - read: go to DRAIN.
- State DRAIN: wait until the last read element has exited the return pipeline. Then go to IDLE; o_done pulses in the cycle after the last o_rd_vld.
- Return pipeline:
  - Read-issue flags and indices are delayed READ_LAT cycles; SRAM data is captured one cycle after issue and delayed READ_LAT-1 further cycles.
  - An element issued in cycle t appears at o_rd_vld/o_rd_idx/o_rd_data in cycle t+READ_LAT.
  - There is no back-pressure; the consumer must accept every element.
- o_busy: 1 in RUN and DRAIN, else 0.
- i_start outside IDLE is ignored.
- Reset mid-transfer aborts immediately: no o_done, no further o_rd_vld.
- Bank counters carry across transfers, so a new transfer can stall on banks touched by the previous one.

Test Plan:
- Read, addr=0x100, stride=1, count=8, defaults -> 8 issues in 8 consecutive cycles, o_conflict_stall never 1; o_rd_vld exactly 11 cycles after each issue with o_rd_idx 0..7 and matching SRAM data; o_done one cycle after the idx-7 return.
- Read, stride=0, count=3 -> issues at t, t+4, t+8; o_conflict_stall=1 for 3 cycles between issues; returns at t+11, t+15, t+19.
- Write, stride=16, count=4 (all bank 0), i_wr_vld always 1 -> o_mem_wr_en at t, t+4, t+8, t+12; o_wr_rdy aligned with those cycles; data written in order; o_done at t+13.
- Write, stride=1, count=4, i_wr_vld low on alternate cycles -> writes only on valid cycles, no stall flag, 4 writes total; then i_count=0 start -> o_done pulse, no o_mem_en.
- Read, addr=0x3FFFFF, stride=1, count=2 -> o_mem_addr 0x3FFFFF then 0x000000; stride=0x3FFFFF (-1) from 0x2 -> addresses 2, 1, 0.
- Assert rst low during RUN after 3 of 8 read issues -> outputs 0 immediately; no o_rd_vld or o_done afterwards; next i_start after release begins with no stall.
